// File: rtl/seq_dtree_pkg.sv
// Shared types and width helpers for the serial decision-tree classifier.
package seq_dtree_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int node_bits_f(input int num_features, input int feat_w,
                                     input int num_nodes);
    return 1 + clog2_min1(num_features) + clog2_min1(feat_w) + feat_w
           + 2 * clog2_min1(num_nodes);
  endfunction

  // Default parameter set: 5 features, 8-bit features, 32 nodes
  localparam int DEF_NUM_FEATURES = 5;
  localparam int DEF_FEAT_W       = 8;
  localparam int DEF_NUM_NODES    = 32;

  localparam int NODE_W    = clog2_min1(DEF_NUM_NODES);
  localparam int FIDX_W    = clog2_min1(DEF_NUM_FEATURES);
  localparam int SH_W      = clog2_min1(DEF_FEAT_W);
  localparam int NODE_BITS = node_bits_f(DEF_NUM_FEATURES, DEF_FEAT_W, DEF_NUM_NODES);

  // Node word layout, LSB upward: f_child | t_child | thr | sh | fidx | leaf
  localparam int F_CHILD_LSB = 0;
  localparam int T_CHILD_LSB = F_CHILD_LSB + NODE_W;
  localparam int THR_LSB     = T_CHILD_LSB + NODE_W;
  localparam int SH_LSB      = THR_LSB + DEF_FEAT_W;
  localparam int FIDX_LSB    = SH_LSB + SH_W;
  localparam int LEAF_BIT    = FIDX_LSB + FIDX_W;

  typedef struct packed {
    logic                  leaf;
    logic [FIDX_W-1:0]     fidx;
    logic [SH_W-1:0]       sh;
    logic [DEF_FEAT_W-1:0] thr;
    logic [NODE_W-1:0]     t_child;
    logic [NODE_W-1:0]     f_child;
  } node_t;

endpackage

// File: rtl/seq_dtree_engine_node_eval.sv
// Combinational evaluation of one tree node against the latched feature vector.
module dtree_node_eval
  import seq_dtree_pkg::*;
#(
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_W       = 8,
  parameter int CLASS_W      = 8,
  parameter int NUM_NODES    = 32,
  parameter int NODE_W       = clog2_min1(NUM_NODES),
  parameter int NODE_BITS    = node_bits_f(NUM_FEATURES, FEAT_W, NUM_NODES)
) (
  input  logic [NODE_BITS-1:0]           node,
  input  logic [NUM_FEATURES*FEAT_W-1:0] features,
  output logic                           is_leaf,
  output logic [NODE_W-1:0]              next_ptr,
  output logic [CLASS_W-1:0]             leaf_class
);

  localparam int FIDX_W_L = clog2_min1(NUM_FEATURES);
  localparam int SH_W_L   = clog2_min1(FEAT_W);
  localparam int F_LSB    = 0;
  localparam int T_LSB    = F_LSB + NODE_W;
  localparam int THR_L    = T_LSB + NODE_W;
  localparam int SH_L     = THR_L + FEAT_W;
  localparam int FIDX_L   = SH_L + SH_W_L;
  localparam int LEAF_L   = FIDX_L + FIDX_W_L;

  logic [FIDX_W_L-1:0] fidx;
  logic [SH_W_L-1:0]   sh;
  logic [FEAT_W-1:0]   thr;
  logic [FEAT_W-1:0]   feat;
  logic [FEAT_W-1:0]   feat_sh;

  assign fidx = node[FIDX_L +: FIDX_W_L];
  assign sh   = node[SH_L +: SH_W_L];
  assign thr  = node[THR_L +: FEAT_W];

  // Out-of-range feature indices match nothing and read as zero
  always_comb begin
    feat = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (fidx == FIDX_W_L'(i)) feat = features[i*FEAT_W +: FEAT_W];
    end
  end

  assign feat_sh    = feat >> sh;
  assign is_leaf    = node[LEAF_L];
  assign next_ptr   = (feat_sh <= thr) ? node[T_LSB +: NODE_W] : node[F_LSB +: NODE_W];
  assign leaf_class = thr[CLASS_W-1:0];

endmodule

// File: rtl/seq_dtree_engine.sv
// Programmable decision-tree classifier: writable node table walked one node per clock.
module seq_dtree_engine
  import seq_dtree_pkg::*;
#(
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_W       = 8,
  parameter int CLASS_W      = 8,
  parameter int NUM_NODES    = 32,
  parameter int MAX_DEPTH    = 15,
  parameter int NODE_W       = clog2_min1(NUM_NODES),
  parameter int NODE_BITS    = node_bits_f(NUM_FEATURES, FEAT_W, NUM_NODES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FEATURES*FEAT_W-1:0] in_features,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLASS_W-1:0]             out_class,
  output logic                           out_err,
  input  logic                           cfg_we,
  input  logic [NODE_W-1:0]              cfg_addr,
  input  logic [NODE_BITS-1:0]           cfg_data,
  output logic                           busy
);

  localparam int DEPTH_W = clog2_min1(MAX_DEPTH + 1);

  state_t                         state;
  logic [NODE_W-1:0]              ptr;
  logic [DEPTH_W-1:0]             depth;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_q;
  logic [NODE_BITS-1:0]           tbl [NUM_NODES];
  logic [NODE_BITS-1:0]           node_rd;
  logic                           ptr_ok;
  logic                           addr_ok;
  logic                           is_leaf;
  logic [NODE_W-1:0]              next_ptr;
  logic [CLASS_W-1:0]             leaf_class;

  // Pointers and addresses past the table end read as zero / drop writes
  if (NUM_NODES == (1 << NODE_W)) begin : g_full
    assign ptr_ok  = 1'b1;
    assign addr_ok = 1'b1;
  end else begin : g_partial
    assign ptr_ok  = (32'(ptr) < NUM_NODES);
    assign addr_ok = (32'(cfg_addr) < NUM_NODES);
  end

  assign node_rd   = ptr_ok ? tbl[ptr] : '0;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  dtree_node_eval #(
    .NUM_FEATURES (NUM_FEATURES),
    .FEAT_W       (FEAT_W),
    .CLASS_W      (CLASS_W),
    .NUM_NODES    (NUM_NODES),
    .NODE_W       (NODE_W),
    .NODE_BITS    (NODE_BITS)
  ) u_eval (
    .node       (node_rd),
    .features   (feat_q),
    .is_leaf    (is_leaf),
    .next_ptr   (next_ptr),
    .leaf_class (leaf_class)
  );

  // Feature capture: data path, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) feat_q <= in_features;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      depth     <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) tbl[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we && addr_ok) tbl[cfg_addr] <= cfg_data;
          if (in_valid) begin
            ptr   <= '0;
            depth <= '0;
            state <= WALK;
          end
        end
        WALK: begin
          if (is_leaf) begin
            out_class <= leaf_class;
            out_err   <= 1'b0;
            state     <= DONE;
          end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
            out_class <= '1;
            out_err   <= 1'b1;
            state     <= DONE;
          end else begin
            ptr   <= next_ptr;
            depth <= depth + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_dtree_engine.sv
// Scoreboard bench for seq_dtree_engine: directed trees, backpressure, config gating, reset.
module tb_seq_dtree_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_features;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_class;
  logic        out_err;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [24:0] cfg_data;
  logic        busy;

  seq_dtree_engine dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_features (in_features),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .out_err     (out_err),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic       e;
    int         lat;
  } exp_t;

  exp_t exq[$];
  int   accq[$];
  int   cyc = 0;
  int   ntot = 0;
  int   npass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else npass++;
  endtask

  function automatic logic [24:0] nw(input logic l, input logic [2:0] fi, input logic [2:0] sh,
                                     input logic [7:0] thr, input logic [4:0] t,
                                     input logic [4:0] f);
    return {l, fi, sh, thr, t, f};
  endfunction

  function automatic logic [39:0] f4v(input logic [7:0] f4);
    return {f4, 32'hA5_3C_77_01};
  endfunction

  // Monitor: latency and stability tracked from the rising edge of out_valid
  logic       prev_v = 1'b0;
  int         rise_lat = 0;
  logic [7:0] hold_c;
  logic       hold_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_v) begin
        hold_c = out_class;
        hold_e = out_err;
        if (accq.size() == 0) begin
          chk("unexpected_result", 1, 0);
          rise_lat = -1;
        end else begin
          rise_lat = cyc - accq.pop_front();
        end
      end else if (out_valid) begin
        chk("hold_class", out_class, hold_c);
        chk("hold_err", out_err, hold_e);
      end
      if (out_valid && out_ready) begin
        if (exq.size() == 0) begin
          chk("result_without_expectation", 1, 0);
        end else begin
          exp_t x;
          x = exq.pop_front();
          chk("class", out_class, x.c);
          chk("err", out_err, x.e);
          chk("latency", rise_lat, x.lat);
        end
      end
    end
    prev_v = out_valid;
  end

  // Handshake one vector; called and returns at posedge+#1
  task automatic send(input logic [39:0] v, input logic [7:0] c, input logic e,
                      input int lat, input bit expect_out);
    int  n = 0;
    bit  ok;
    exp_t x;
    if (expect_out) begin
      x.c = c; x.e = e; x.lat = lat;
      exq.push_back(x);
    end
    in_features = v;
    in_valid    = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #1;
    if (!ok) chk("accept_timeout", 0, 1);
    if (expect_out) accq.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [24:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exq.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (exq.size() == 0 && !busy), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_features = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // All-zero table self-loops into depth abort
    send(f4v(8'h12), 8'hFF, 1'b1, 16, 1'b1);
    wait_idle();

    // Single leaf at root
    cfg_write(5'd0, nw(1'b1, 3'd0, 3'd0, 8'd167, 5'd0, 5'd0));
    send(f4v(8'h99), 8'd167, 1'b0, 1, 1'b1);
    wait_idle();

    // Two-level tree on feature4 top two bits
    cfg_write(5'd0, nw(1'b0, 3'd4, 3'd6, 8'd0, 5'd1, 5'd2));
    cfg_write(5'd1, nw(1'b1, 3'd0, 3'd0, 8'd167, 5'd0, 5'd0));
    cfg_write(5'd2, nw(1'b1, 3'd0, 3'd0, 8'd24, 5'd0, 5'd0));
    send(f4v(8'h3F), 8'd167, 1'b0, 2, 1'b1);
    wait_idle();
    send(f4v(8'h40), 8'd24, 1'b0, 2, 1'b1);
    wait_idle();

    // Out-of-range feature index reads as zero, so 0 <= 0 takes the true child
    cfg_write(5'd0, nw(1'b0, 3'd7, 3'd0, 8'd0, 5'd1, 5'd2));
    send(40'hFF_FF_FF_FF_FF, 8'd167, 1'b0, 2, 1'b1);
    wait_idle();
    cfg_write(5'd0, nw(1'b0, 3'd4, 3'd6, 8'd0, 5'd1, 5'd2));

    // Backpressure with a second vector waiting
    send(f4v(8'h3F), 8'd167, 1'b0, 2, 1'b1);
    out_ready = 1'b0;
    in_features = f4v(8'h40);
    in_valid = 1'b1;
    begin
      exp_t x;
      x.c = 8'd24; x.e = 1'b0; x.lat = 2;
      exq.push_back(x);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("bp_valid_held", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_still_low", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_valid_dropped", out_valid, 0);
    @(posedge clk); #1;
    accq.push_back(cyc);
    in_valid = 1'b0;
    wait_idle();

    // Config write during WALK is dropped
    send(f4v(8'h3F), 8'd167, 1'b0, 2, 1'b1);
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = nw(1'b1, 3'd0, 3'd0, 8'd99, 5'd0, 5'd0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_idle();
    send(f4v(8'h3F), 8'd167, 1'b0, 2, 1'b1);
    wait_idle();

    // Write and handshake in the same IDLE cycle: walk sees the new node
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = nw(1'b1, 3'd0, 3'd0, 8'd77, 5'd0, 5'd0);
    send(f4v(8'h3F), 8'd77, 1'b0, 2, 1'b1);
    cfg_we = 1'b0;
    wait_idle();

    // Reset in the second WALK cycle loses the result and clears the table
    send(f4v(8'h3F), 8'd0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_class", out_class, 0);
    @(posedge clk); #1;
    send(f4v(8'h3F), 8'hFF, 1'b1, 16, 1'b1);
    wait_idle();

    chk("scoreboard_empty", exq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
